gray_code_counter: RTL and testbench
====================================

# gray_code_counter

Parameterised binary-to-Gray counter: holds an N-bit binary count and presents it as registered Gray code. Each step changes exactly one output bit. It is the encode/source side that pairs with the team's combinational Gray-to-binary decoder. It feeds multi-bit pointers and position codes across clock-domain or mechanical boundaries, where the receiving side decodes back to binary.

## Interface
- WIDTH, default 4, count width in bits; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance count by one step this cycle.
- load  input  1  load `load_bin` this cycle; overrides `en`.
- load_bin  input  WIDTH  binary value to load.
- dir  input  1  count direction: 1 = up, 0 = down. Present only with GRAY_UPDOWN_EN.
- gray  output  WIDTH  registered Gray code of the current count.
- bin  output  WIDTH  registered binary count.
- tc  output  1  terminal count: current count is the last value before wrap in the active direction.

## Operation
- State: binary count register `cnt[WIDTH-1:0]` and Gray register `gray_q[WIDTH-1:0]`. `bin` = `cnt`; `gray` = `gray_q`.
- Encoding rule: gray = b ^ (b >> 1). MSB passes through; bit i = b[i+1] ^ b[i].
- Next-count rule, evaluated at each rising edge in strict priority order:
  - `rst`: cnt ← 0.
  - `load`: cnt ← `load_bin`.
  - `en`: cnt ← cnt + 1 when counting up, or cnt − 1 when counting down. Arithmetic is modulo 2^WIDTH.
  - Otherwise: cnt holds.
- `gray_q` ← encode(next cnt) on the same edge, so `gray` and `bin` always correspond. There is no cycle of skew between them.
- Wrap-around:
  - Up count: all-ones → 0. Gray goes 100…0 → 000…0, a single-bit change.
  - Down count: 0 → all-ones. This is the reverse transition.
- `tc` is combinational from registered state and the current `dir`:
  - `tc` = (cnt == all-ones) when counting up.
  - `tc` = (cnt == 0) when counting down.
  - `tc` is not gated by `en`.
- `load` and `en` asserted together: the load wins and no increment is applied to the loaded value.
- `rst` asserted mid-sequence, or together with `load`/`en`: the count returns to 0 on that edge. All other inputs are ignored that cycle.
- Single-bit-change guarantee: every `en` step changes exactly one bit of `gray`. A `load` may change any number of bits.

## Timing
- Reset values:
  - `bin` = 0, `gray` = 0.
  - `tc` = 0 when counting up. Without GRAY_UPDOWN_EN the direction is always up, so `tc` = 0.
  - `tc` = 1 when `dir` = 0, because the count is 0.
- Latency: one clock from `en`/`load` sampled at edge k to the new `bin`/`gray` visible after edge k.
- Throughput: one step per cycle with `en` held high.
- `dir` is sampled at the same edge as `en`. Changing `dir` between steps reverses the sequence with no dead cycle.
- `gray` and `bin` come directly from flops; there is no output combinational path.

## Configuration
- GRAY_UPDOWN_EN defined:
  - The `dir` port exists.
  - Up/down counting and the direction-dependent `tc` apply as above.
- GRAY_UPDOWN_EN undefined:
  - No `dir` port; the direction is hard-wired up.
  - Decrement logic is not built.
  - `tc` = (cnt == all-ones).

## Structure
- Shared package `gray_pkg`:
  - function `bin2gray(logic [15:0])`, masked to WIDTH at use.
  - localparam WIDTH_MAX = 16.
  - Direction constants DIR_UP = 1'b1 and DIR_DOWN = 1'b0.
- One sub-module: `bin2gray_enc`, a combinational WIDTH-parameterised encoder. It is instantiated on the next-count path so the counter and any future standalone encoder share one implementation.

## Test plan
1. **Reset:** `rst` = 1 for 2 cycles, WIDTH = 4 → `bin` = 0000, `gray` = 0000, `tc` = 0 (dir = up).
2. **Full up sweep:** `en` = 1 for 16 cycles from 0.
   - `gray` sequence is 0000, 0001, 0011, 0010, 0110, … 1000, then 0000.
   - Exactly one bit changes per step.
   - `tc` = 1 only while `bin` = 1111.
3. **Load priority:** `load` = 1, `en` = 1, `load_bin` = 0101 → next cycle `bin` = 0101, `gray` = 0111 (no increment).
4. **Down wrap (GRAY_UPDOWN_EN):** load 0001, then dir = 0 with `en` for 2 cycles.
   - `bin` = 0000 with `tc` = 1.
   - Then `bin` = 1111, `gray` = 1000.
5. **Reset mid-count:** count to 1010, then assert `rst` with `en` = 1 → next cycle `bin` = 0000, `gray` = 0000.
6. **Round-trip:** feed `gray` into the team's Gray-to-binary decoder over a 256-step random `en`/`load`/`dir` run (WIDTH = 8) → decoded value equals `bin` every cycle.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and constants for the counter and encoder.
// Purely declarative: no latency, no flow control.
package gray_pkg;

  localparam int WIDTH_MAX = 16;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Callers zero-extend their count to WIDTH_MAX and truncate the result back.
  function automatic logic [WIDTH_MAX-1:0] bin2gray(input logic [WIDTH_MAX-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/bin2gray_enc.sv
// Combinational WIDTH-bit binary-to-Gray encoder built on the package helper.
// Zero latency, no flow control; output follows input in the same cycle.
module bin2gray_enc
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = WIDTH'(bin2gray(WIDTH_MAX'(bin)));

endmodule

// File: rtl/gray_code_counter.sv
// Binary counter with registered Gray output; bin/gray update one clock after en/load, no backpressure.
// GRAY_UPDOWN_EN adds the dir port and down counting; otherwise the counter only counts up.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
`ifdef GRAY_UPDOWN_EN
  input  logic             dir,
`endif
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             tc
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] gray_q;
  logic [WIDTH-1:0] gray_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (load) begin
      cnt_nxt = load_bin;
    end else if (en) begin
`ifdef GRAY_UPDOWN_EN
      cnt_nxt = (dir == DIR_UP) ? cnt + WIDTH'(1) : cnt - WIDTH'(1);
`else
      cnt_nxt = cnt + WIDTH'(1);
`endif
    end
  end

  // Encoding the next count keeps gray and bin aligned on the same edge.
  bin2gray_enc #(.WIDTH(WIDTH)) u_enc (
    .bin  (cnt_nxt),
    .gray (gray_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      gray_q <= '0;
    end else begin
      cnt    <= cnt_nxt;
      gray_q <= gray_nxt;
    end
  end

  assign bin  = cnt;
  assign gray = gray_q;

`ifdef GRAY_UPDOWN_EN
  assign tc = (dir == DIR_UP) ? (cnt == ALL_ONES) : (cnt == '0);
`else
  assign tc = (cnt == ALL_ONES);
`endif

endmodule

// File: tb/tb_gray_code_counter.sv
// Scoreboard bench: directed WIDTH=4 vectors plus a WIDTH=8 random run decoded back to binary.
// Define GRAY_UPDOWN_EN to also exercise the dir port and down counting.
module tb_gray_code_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, load;
  logic [3:0] load_bin, gray, bin;
  logic       tc;
  logic       rst8, en8, load8;
  logic [7:0] load_bin8, gray8, bin8;
  logic       tc8;
`ifdef GRAY_UPDOWN_EN
  logic       dir, dir8;
`endif

  gray_code_counter #(.WIDTH(4)) u_dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_bin(load_bin),
`ifdef GRAY_UPDOWN_EN
    .dir(dir),
`endif
    .gray(gray), .bin(bin), .tc(tc)
  );

  gray_code_counter #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .en(en8), .load(load8), .load_bin(load_bin8),
`ifdef GRAY_UPDOWN_EN
    .dir(dir8),
`endif
    .gray(gray8), .bin(bin8), .tc(tc8)
  );

  typedef struct {
    logic [3:0] bin;
    logic [3:0] gray;
    logic       tc;
    logic       one_bit;
    string      tag;
  } exp4_t;

  typedef struct {
    logic [7:0] bin;
    logic       tc;
    logic       one_bit;
  } exp8_t;

  exp4_t q4[$];
  exp8_t q8[$];
  int    checks = 0;
  int    errors = 0;

  function automatic logic [7:0] gray2bin8(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step4(input logic r, input logic l, input logic e, input logic [3:0] lb,
                       input logic d, input logic [3:0] eb, input logic [3:0] eg,
                       input logic et, input string tag);
    exp4_t x;
    @(negedge clk);
    rst = r; load = l; en = e; load_bin = lb;
`ifdef GRAY_UPDOWN_EN
    dir = d;
`endif
    x.bin = eb; x.gray = eg; x.tc = et; x.one_bit = e && !l && !r; x.tag = tag;
    // A direction argument other than up only makes sense with the dir port present.
    if (d !== 1'b1) x.tag = {tag, "_dn"};
    q4.push_back(x);
  endtask

  // Monitor: every output sample is compared against the oldest queued expectation.
  initial begin
    exp4_t      e4;
    exp8_t      e8;
    logic [3:0] pg4;
    logic [7:0] pg8;
    pg4 = '0;
    pg8 = '0;
    forever begin
      @(posedge clk);
      #1;
      if (q4.size() > 0) begin
        e4 = q4.pop_front();
        check({e4.tag, " bin"},  16'(bin),  16'(e4.bin));
        check({e4.tag, " gray"}, 16'(gray), 16'(e4.gray));
        check({e4.tag, " tc"},   16'(tc),   16'(e4.tc));
        if (e4.one_bit) check({e4.tag, " one_bit"}, 16'($countones(gray ^ pg4)), 16'd1);
      end
      if (q8.size() > 0) begin
        e8 = q8.pop_front();
        check("rt bin",     16'(bin8),            16'(e8.bin));
        check("rt decoded", 16'(gray2bin8(gray8)), 16'(e8.bin));
        check("rt tc",      16'(tc8),             16'(e8.tc));
        if (e8.one_bit) check("rt one_bit", 16'($countones(gray8 ^ pg8)), 16'd1);
      end
      pg4 = gray;
      pg8 = gray8;
    end
  end

  initial begin
    logic [3:0] gtab [16];
    logic [7:0] m8, lb8;
    logic       r8, l8, e8b, d8;
    exp8_t      x8;
    int         idx;

    gtab[0]  = 4'h0; gtab[1]  = 4'h1; gtab[2]  = 4'h3; gtab[3]  = 4'h2;
    gtab[4]  = 4'h6; gtab[5]  = 4'h7; gtab[6]  = 4'h5; gtab[7]  = 4'h4;
    gtab[8]  = 4'hC; gtab[9]  = 4'hD; gtab[10] = 4'hF; gtab[11] = 4'hE;
    gtab[12] = 4'hA; gtab[13] = 4'hB; gtab[14] = 4'h9; gtab[15] = 4'h8;

    rst = 1'b1; en = 1'b0; load = 1'b0; load_bin = '0;
    rst8 = 1'b1; en8 = 1'b0; load8 = 1'b0; load_bin8 = '0;
`ifdef GRAY_UPDOWN_EN
    dir = 1'b1; dir8 = 1'b1;
`endif

    step4(1, 0, 0, 4'h0, 1, 4'h0, 4'h0, 0, "reset0");
    step4(1, 0, 0, 4'h0, 1, 4'h0, 4'h0, 0, "reset1");

    for (int i = 1; i <= 16; i++) begin
      idx = i % 16;
      step4(0, 0, 1, 4'h0, 1, 4'(idx), gtab[idx], idx == 15, $sformatf("sweep%0d", i));
    end

    step4(0, 0, 0, 4'h0, 1, 4'h0, 4'h0, 0, "hold");
    step4(0, 1, 1, 4'h5, 1, 4'h5, 4'h7, 0, "load_pri");
    step4(0, 0, 1, 4'h0, 1, 4'h6, 4'h5, 0, "after_load");

`ifdef GRAY_UPDOWN_EN
    step4(0, 1, 0, 4'h1, 1, 4'h1, 4'h1, 0, "dn_load");
    step4(0, 0, 1, 4'h0, 0, 4'h0, 4'h0, 1, "dn_step0");
    step4(0, 0, 1, 4'h0, 0, 4'hF, 4'h8, 0, "dn_wrap");
    step4(0, 0, 1, 4'h0, 0, 4'hE, 4'h9, 0, "dn_step2");
    step4(0, 0, 1, 4'h0, 1, 4'hF, 4'h8, 1, "dn_reverse");
`endif

    step4(0, 1, 0, 4'h9, 1, 4'h9, 4'hD, 0, "mid_load");
    step4(0, 0, 1, 4'h0, 1, 4'hA, 4'hF, 0, "mid_step");
    step4(1, 1, 1, 4'hF, 1, 4'h0, 4'h0, 0, "mid_rst");

    @(negedge clk);
    rst = 1'b0; load = 1'b0; en = 1'b0;

    m8 = '0;
    for (int i = 0; i < 256; i++) begin
      r8  = ($urandom_range(31) == 0);
      l8  = ($urandom_range(7) == 0);
      e8b = 1'($urandom_range(1));
      lb8 = 8'($urandom);
`ifdef GRAY_UPDOWN_EN
      d8  = 1'($urandom_range(1));
`else
      d8  = 1'b1;
`endif
      @(negedge clk);
      rst8 = r8; load8 = l8; en8 = e8b; load_bin8 = lb8;
`ifdef GRAY_UPDOWN_EN
      dir8 = d8;
`endif
      if (r8)       m8 = '0;
      else if (l8)  m8 = lb8;
      else if (e8b) m8 = d8 ? m8 + 8'd1 : m8 - 8'd1;
      x8.bin     = m8;
      x8.tc      = d8 ? (m8 == 8'hFF) : (m8 == 8'h00);
      x8.one_bit = e8b && !l8 && !r8;
      q8.push_back(x8);
    end

    @(negedge clk);
    en8 = 1'b0; load8 = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    if (q4.size() != 0 || q8.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d expectations left, required 0", q4.size(), q8.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
